// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first W-bit a - b - bin with start/busy/done handshake.
// Define SERIAL_SUB_FLAGS_EN to add registered zero/neg result flags.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic         zero,
    output logic         neg
`endif
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t         st;
    logic [CW-1:0]  cnt;
    logic           br;
    logic [W-1:0]   sa, sb, sr;
    logic           di, bn;
    logic [W-1:0]   nr;
    always_comb begin
        di = sa[0] ^ sb[0] ^ br;
        bn = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        nr = {di, sr[W-1:1]};
    end
    // DONE behaves like IDLE for start acceptance, giving back-to-back ops with no gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            cnt  <= '0;
            br   <= 1'b0;
            sa   <= '0;
            sb   <= '0;
            sr   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero <= 1'b0;
            neg  <= 1'b0;
`endif
        end else if (st == SHIFT) begin
            sr <= nr;
            sa <= sa >> 1;
            sb <= sb >> 1;
            br <= bn;
            if (cnt == CW'(W - 1)) begin
                st   <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
                diff <= nr;
                bout <= bn;
                ovf  <= br ^ bn;
`ifdef SERIAL_SUB_FLAGS_EN
                zero <= (nr == '0);
                neg  <= di;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (start) begin
            st   <= SHIFT;
            sa   <= a;
            sb   <= b;
            br   <= bin;
            cnt  <= '0;
            sr   <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else begin
            st   <= IDLE;
            done <= 1'b0;
        end
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor, LSB first, one bit per clock; computes a - b - bin.
- Each bit-slice is a full subtractor with a registered borrow.
- Start/busy/done handshake for area-constrained datapaths.
- Inverse counterpart of the team's adder blocks; shares their operand conventions: unsigned magnitude, two's-complement overflow.

Parameters:
- W, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk    input   1  rising-edge clock, single clock domain
- rst    input   1  asynchronous, active-high reset
- start  input   1  request; sampled only when busy=0
- a      input   W  minuend, captured on accepted start
- b      input   W  subtrahend, captured on accepted start
- bin    input   1  borrow-in, captured on accepted start
- busy   output  1  high while the operation is in progress
- done   output  1  single-cycle pulse: result valid
- diff   output  W  (a - b - bin) mod 2^W
- bout   output  1  unsigned borrow-out: 1 iff a < b + bin
- ovf    output  1  two's-complement overflow: borrow into MSB XOR borrow out of MSB

Behaviour:
- Reset is asynchronous: on rst=1, immediately state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, bit counter=0, borrow reg=0, operand shift regs=0.
- States:
  - IDLE -> SHIFT when start=1 at an edge. At that edge: capture a, b; borrow reg <= bin; counter <= 0; busy <= 1; result shift reg cleared.
  - SHIFT: each edge processes bit i=counter.
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result register MSB side; operands shift right; counter increments.
    - At the edge where counter = W-1: latch ovf = br_in(MSB) ^ br'(MSB); bout = br'; diff = final shifted result. Go to DONE, busy <= 0, done <= 1.
  - DONE: lasts one cycle. done=1, busy=0. Next edge -> IDLE with done <= 0.
  - Start during DONE is accepted exactly as from IDLE: SHIFT entered, busy=1, done=0 next cycle.
- Latency: start accepted at edge E0; busy=1 after E0 through edge EW; done=1 in the cycle after EW (W+1 edges after E0); throughput one operation per W+1 cycles.
- start while busy=1 is ignored; captured operands unaffected; no error flag.
- diff/bout/ovf update only at the final SHIFT edge and hold stable until the next final edge. Intermediate bits are not visible on diff.
- a/b/bin may change freely after the accepting edge.
- rst asserted mid-operation aborts; no done pulse; outputs return to reset values.
- Counter width = clog2(W); no wrap beyond W-1.

Optional Feature:
- Macro SERIAL_SUB_FLAGS_EN.
- Defined: adds outputs zero (1 bit, diff==0) and neg (1 bit, diff[W-1]). Both are registered, updated at the final SHIFT edge alongside diff, and reset to 0.
- Undefined: ports absent; no extra logic; all other behaviour identical.

Test Plan:
- W=8, start with a=0x5A, b=0x3C, bin=0 -> done pulses exactly 9 cycles after the accepting edge; diff=0x1E, bout=0, ovf=0; busy high for 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0 (flags build: zero=0, neg=1).
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF, bin=1 -> diff=0x7F, bout=1, ovf=0.
- Start a=0x10, b=0x10, bin=0, then pulse start with a=0xFF, b=0x00 at cycle 3 -> second start ignored; diff=0x00, bout=0 (flags: zero=1); start held high in the DONE cycle launches the next op with no idle gap.
- Assert rst at cycle 4 of an op on a=0xAA, b=0x55 -> busy/done/diff/bout/ovf=0 asynchronously; no done pulse; a new start after release yields correct diff=0x55.
- Back-to-back random sweep, 1000 ops, bin random -> every diff/bout/ovf matches the reference model; every done is exactly W+1 cycles after its start.
